mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: data width of all data buses.
REQ-002 Parameter ADDR_W, default 16: address width of all address buses.
REQ-003 clk  input  1: single clock; all state changes on rising edge.
REQ-004 reset  input  1: one clock; reset is asynchronous and active-low.
REQ-005 cpu_req  input  1: CPU access request; held high until cpu_gnt.
REQ-006 cpu_we  input  1: CPU access is a write (1) or read (0).
REQ-007 cpu_addr  input  ADDR_W: CPU access address.
REQ-008 cpu_wdata  input  WIDTH: CPU write data.
REQ-009 cpu_gnt  output  1: one-cycle pulse; CPU access issued to memory this cycle.
REQ-010 cpu_rvalid  output  1: one-cycle pulse; cpu_rdata valid.
REQ-011 cpu_rdata  output  WIDTH: registered CPU read data.
REQ-012 io_req, io_we, io_addr, io_wdata, io_gnt, io_rvalid, io_rdata: same directions, widths and meanings as the cpu_* ports, for the I/O requester.
REQ-013 mem_en  output  1: memory access strobe.
REQ-014 mem_we  output  1: memory write enable; only high while mem_en is high.
REQ-015 mem_addr  output  ADDR_W: memory address.
REQ-016 mem_wdata  output  WIDTH: memory write data.
REQ-017 mem_rdata  input  WIDTH: memory read data, valid the cycle after a read strobe.
REQ-018 busy  output  1: high in any state other than IDLE.
REQ-019 stall_cnt  output  16: count of cycles in which a request was pending but not granted.

Function
REQ-020 The FSM SHALL have three states: IDLE, ISSUE, RD_WAIT.
REQ-021 In IDLE with any req high, the block SHALL select an owner, register owner/we/addr/wdata, and move to ISSUE on the next edge.
REQ-022 If only one req is high, that requester SHALL be the owner.
REQ-023 If both reqs are high, the owner SHALL be the requester not granted most recently (round-robin via a last_owner bit).
REQ-024 In ISSUE, mem_en=1, mem_we/mem_addr/mem_wdata SHALL come from the registered request, and the owner's gnt SHALL pulse for exactly this cycle.
REQ-025 From ISSUE, a write SHALL return to IDLE and a read SHALL go to RD_WAIT; last_owner SHALL update to the owner.
REQ-026 In RD_WAIT, the owner's rdata register SHALL capture mem_rdata; the owner's rvalid SHALL pulse the following cycle, concurrent with the state's return to IDLE.
REQ-027 Latency from req rise (in IDLE) to gnt SHALL be 1 cycle, and to rvalid 3 cycles; a write occupies 2 cycles and a read 3 cycles.
REQ-028 rdata registers SHALL hold their value until their own next read completes; the non-owner rdata SHALL never change.
REQ-029 mem_en, mem_we and both gnt signals SHALL be 0 in IDLE and RD_WAIT.
REQ-030 Requests in ISSUE or RD_WAIT SHALL NOT be sampled; a requester dropping req before gnt SHALL have its request withdrawn without error.
REQ-031 stall_cnt SHALL increment by 1 each cycle in which a req is high and that requester's gnt is low, by 2 if both apply, and SHALL saturate at 16'hFFFF.
REQ-032 With both requesters continuously requesting, grants SHALL strictly alternate, so neither waits more than one foreign access.

Reset
REQ-033 On reset low, the block SHALL asynchronously enter IDLE, with last_owner=IO (CPU wins the first tie) and stall_cnt=0.
REQ-034 During reset, every output, including rdata registers and rvalid, SHALL be 0.
REQ-035 Reset during ISSUE or RD_WAIT SHALL abort the access with no rvalid pulse; mem_en SHALL drop immediately.

Verification
REQ-036 CPU-only write: cpu_req=1, we=1, addr=16'h0010, wdata=16'hBEEF -> one cycle later, mem_en=mem_we=1 with that addr/data and cpu_gnt pulses; busy falls after 2 cycles.
REQ-037 CPU-only read: addr=16'h0010, mem returns 16'hBEEF -> cpu_rvalid pulses 3 cycles after req with cpu_rdata=16'hBEEF; io_rdata stays 0.
REQ-038 Simultaneous reads after reset -> CPU is granted first, then IO; grants alternate CPU, IO, CPU, IO over 4 accesses; stall_cnt matches the waiting-cycle count exactly.
REQ-039 Reset asserted in RD_WAIT -> outputs go to 0 without waiting for a clock edge; no rvalid pulse follows; after release, the first tie goes to CPU.
REQ-040 Hold io_req high with stall_cnt preloaded near 16'hFFFF via a long CPU stream -> stall_cnt saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports, the shared memory port,
// and status outputs. The arbiter connects through the slave modport.
interface mem_arbiter_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WIDTH-1:0]  cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [WIDTH-1:0]  cpu_rdata;

    logic              io_req;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [WIDTH-1:0]  io_wdata;
    logic              io_gnt;
    logic              io_rvalid;
    logic [WIDTH-1:0]  io_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    logic              busy;
    logic [15:0]       stall_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  io_req, io_we, io_addr, io_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output io_gnt, io_rvalid, io_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, stall_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output io_req, io_we, io_addr, io_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  io_gnt, io_rvalid, io_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, stall_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / IO) round-robin arbiter onto a single memory port.
// Write: IDLE -> ISSUE -> IDLE. Read: IDLE -> ISSUE -> RD_WAIT -> IDLE,
// with the owner's rvalid pulsing in the cycle after RD_WAIT.
module mem_arbiter #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    state_t            state;
    state_t            state_nxt;

    logic              owner;        // 0 = CPU, 1 = IO
    logic              last_owner;   // 0 = CPU, 1 = IO
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;
    logic [WIDTH-1:0]  cpu_rdata_q;
    logic [WIDTH-1:0]  io_rdata_q;
    logic              cpu_rvalid_q;
    logic              io_rvalid_q;
    logic [15:0]       stall_q;

    logic              any_req;
    logic              pick_io;
    logic              cpu_gnt_c;
    logic              io_gnt_c;
    logic [1:0]        stall_inc;
    logic [16:0]       stall_sum;

    // Owner selection: a tie goes to whoever was not granted last
    always_comb begin
        any_req = bus.cpu_req | bus.io_req;
        if (bus.cpu_req && bus.io_req)
            pick_io = ~last_owner;
        else
            pick_io = bus.io_req;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = r_we ? IDLE : RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; memory bus is zero outside ISSUE
    always_comb begin
        cpu_gnt_c      = 1'b0;
        io_gnt_c       = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.busy       = (state != IDLE);
        if (state == ISSUE) begin
            cpu_gnt_c     = ~owner;
            io_gnt_c      = owner;
            bus.mem_en    = 1'b1;
            bus.mem_we    = r_we;
            bus.mem_addr  = r_addr;
            bus.mem_wdata = r_wdata;
        end
        bus.cpu_gnt    = cpu_gnt_c;
        bus.io_gnt     = io_gnt_c;
        bus.cpu_rvalid = cpu_rvalid_q;
        bus.io_rvalid  = io_rvalid_q;
        bus.cpu_rdata  = cpu_rdata_q;
        bus.io_rdata   = io_rdata_q;
        bus.stall_cnt  = stall_q;
    end

    // Latch the winning request in IDLE; remember the owner once issued
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner   <= pick_io;
                r_we    <= pick_io ? bus.io_we    : bus.cpu_we;
                r_addr  <= pick_io ? bus.io_addr  : bus.cpu_addr;
                r_wdata <= pick_io ? bus.io_wdata : bus.cpu_wdata;
            end
            if (state == ISSUE)
                last_owner <= owner;
        end
    end

    // Capture read data for the owner only; rvalid is a one-cycle pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q  <= '0;
            io_rdata_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            io_rvalid_q  <= 1'b0;
        end else begin
            cpu_rvalid_q <= 1'b0;
            io_rvalid_q  <= 1'b0;
            if (state == RD_WAIT) begin
                if (owner) begin
                    io_rdata_q  <= bus.mem_rdata;
                    io_rvalid_q <= 1'b1;
                end else begin
                    cpu_rdata_q  <= bus.mem_rdata;
                    cpu_rvalid_q <= 1'b1;
                end
            end
        end
    end

    // Per-cycle count of requesters left waiting, saturating
    always_comb begin
        stall_inc = {1'b0, bus.cpu_req & ~cpu_gnt_c} + {1'b0, bus.io_req & ~io_gnt_c};
        stall_sum = {1'b0, stall_q} + {15'd0, stall_inc};
    end

    // Stall counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_q <= '0;
        else
            stall_q <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end
endmodule
